// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the IF-stage redirect/stall controller.
//   state_t     : controller FSM states
//   redir_src_t : which redirect source won arbitration this cycle
//   redir_select: fixed-priority arbiter exception > branch > jump
package fetch_redirect_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR = 32'h80000180;
    localparam logic [31:0] RESET_PC   = 32'h00400000;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MDU_WAIT   = 2'd1,
        REDIR_PEND = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_JUMP   = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_EXC    = 2'd3
    } redir_src_t;

    // Fixed-priority pick of the redirect source.
    function automatic redir_src_t redir_select(input logic exc, input logic br, input logic jmp);
        if (exc)      return SRC_EXC;
        else if (br)  return SRC_BRANCH;
        else if (jmp) return SRC_JUMP;
        else          return SRC_NONE;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
//   ex_memread, ex_rt            : load in EX and its destination register
//   id_rs, id_rt, id_uses_rs/rt  : source registers read by the ID instruction
//   hazard_c                     : combinational hazard flag
module load_use_detect (
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    output logic       hazard_c
);

    // $zero never carries a dependency.
    always_comb begin
        hazard_c = ex_memread && (ex_rt != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// IF-stage PC sequencer: arbitrates exception/branch/jump redirects, holds a
// redirect while imem is busy, and raises stall/flush for load-use hazards,
// multi-cycle MDU ops and imem wait. No branch delay slot.
//   inputs : imem_ready, ID source regs, EX load info, redirect sources, mdu_start
//   outputs: jumpif/jumpaddr/stall to PC, stall_id/flush_id/flush_ex to the
//            pipeline registers, mdu_busy/redirect_pending state flags
// Outputs are combinational from state and inputs; the PC acts on them at the
// next clock edge.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = fetch_redirect_ctrl_pkg::EXC_VECTOR,
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        id_jump,
    input  logic [31:0] id_jump_target,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    input  logic        exc_req,
    input  logic        mdu_start,
    output logic        jumpif,
    output logic [31:0] jumpaddr,
    output logic        stall,
    output logic        stall_id,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        mdu_busy,
    output logic        redirect_pending
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      pend_addr, pend_addr_n;
    logic             hazard_c;
    redir_src_t       src_c;
    logic [31:0]      redir_addr_c;
    logic [31:0]      pend_issue_c;

    load_use_detect u_load_use_detect (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .hazard_c   (hazard_c)
    );

    // Winning redirect source and its target.
    always_comb begin
        src_c = redir_select(exc_req, ex_branch_taken, id_jump);
        case (src_c)
            SRC_EXC:    redir_addr_c = EXC_VECTOR;
            SRC_BRANCH: redir_addr_c = ex_branch_target;
            SRC_JUMP:   redir_addr_c = id_jump_target;
            default:    redir_addr_c = 32'h0;
        endcase
        // An exception arriving while a redirect is held replaces the held target.
        pend_issue_c = exc_req ? EXC_VECTOR : pend_addr;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            pend_addr <= 32'h0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pend_addr <= pend_addr_n;
        end
    end

    // Next state and outputs.
    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        pend_addr_n      = pend_addr;
        jumpif           = 1'b0;
        jumpaddr         = 32'h0;
        stall            = 1'b0;
        stall_id         = 1'b0;
        flush_id         = 1'b0;
        flush_ex         = 1'b0;
        mdu_busy         = 1'b0;
        redirect_pending = 1'b0;

        case (state)
            RUN: begin
                if (src_c != SRC_NONE) begin
                    flush_id = 1'b1;
                    flush_ex = (src_c != SRC_JUMP);
                    jumpaddr = redir_addr_c;
                    if (imem_ready) begin
                        jumpif = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        pend_addr_n = redir_addr_c;
                        state_n     = REDIR_PEND;
                    end
                end else if (mdu_start) begin
                    state_n = MDU_WAIT;
                    cnt_n   = CNT_W'(MDU_LATENCY - 1);
                end else if (hazard_c || !imem_ready) begin
                    stall    = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
            end

            MDU_WAIT: begin
                mdu_busy = 1'b1;
                if (exc_req) begin
                    // Exception aborts the MDU wait.
                    flush_id = 1'b1;
                    flush_ex = 1'b1;
                    jumpaddr = EXC_VECTOR;
                    cnt_n    = '0;
                    if (imem_ready) begin
                        jumpif  = 1'b1;
                        state_n = RUN;
                    end else begin
                        stall       = 1'b1;
                        pend_addr_n = EXC_VECTOR;
                        state_n     = REDIR_PEND;
                    end
                end else begin
                    stall    = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                    if (cnt == '0) state_n = RUN;
                    else           cnt_n   = cnt - CNT_W'(1);
                end
            end

            REDIR_PEND: begin
                redirect_pending = 1'b1;
                flush_id         = 1'b1;
                flush_ex         = 1'b1;
                jumpaddr         = pend_issue_c;
                pend_addr_n      = pend_issue_c;
                if (imem_ready) begin
                    jumpif  = 1'b1;
                    state_n = RUN;
                end else begin
                    stall = 1'b1;
                end
            end

            default: state_n = RUN;
        endcase

        // Reset forces every output low.
        if (rst) begin
            jumpif           = 1'b0;
            jumpaddr         = 32'h0;
            stall            = 1'b0;
            stall_id         = 1'b0;
            flush_id         = 1'b0;
            flush_ex         = 1'b0;
            mdu_busy         = 1'b0;
            redirect_pending = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl.
// Output flag vector: {jumpif, stall, stall_id, flush_id, flush_ex, mdu_busy, redirect_pending}
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_memread;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        exc_req;
    logic        mdu_start;
    logic        jumpif, stall, stall_id, flush_id, flush_ex, mdu_busy, redirect_pending;
    logic [31:0] jumpaddr;
    logic [6:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] EXC = 32'h80000180;
    // Expected flag patterns
    localparam logic [6:0] F_IDLE     = 7'b0000000;
    localparam logic [6:0] F_HAZ      = 7'b0110100;
    localparam logic [6:0] F_REDIR    = 7'b1001100;
    localparam logic [6:0] F_JUMP     = 7'b1001000;
    localparam logic [6:0] F_MDU      = 7'b0110110;
    localparam logic [6:0] F_MDU_EXC  = 7'b1001110;
    localparam logic [6:0] F_MDU_EXCW = 7'b0101110;
    localparam logic [6:0] F_HOLD0    = 7'b0101100;
    localparam logic [6:0] F_PEND     = 7'b0101101;
    localparam logic [6:0] F_PEND_GO  = 7'b1001101;

    assign flags = {jumpif, stall, stall_id, flush_id, flush_ex, mdu_busy, redirect_pending};

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .imem_ready       (imem_ready),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .ex_memread       (ex_memread),
        .ex_rt            (ex_rt),
        .id_jump          (id_jump),
        .id_jump_target   (id_jump_target),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .exc_req          (exc_req),
        .mdu_start        (mdu_start),
        .jumpif           (jumpif),
        .jumpaddr         (jumpaddr),
        .stall            (stall),
        .stall_id         (stall_id),
        .flush_id         (flush_id),
        .flush_ex         (flush_ex),
        .mdu_busy         (mdu_busy),
        .redirect_pending (redirect_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, inputs back to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        rst = 1'b0; imem_ready = 1'b1;
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
        id_jump = 1'b0; id_jump_target = '0;
        ex_branch_taken = 1'b0; ex_branch_target = '0;
        exc_req = 1'b0; mdu_start = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [6:0] exp);
        #1;
        check(tag, 32'(flags), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        next_cycle();
        // Reset with active stimulus: all outputs must be low.
        rst = 1'b1; exc_req = 1'b1; imem_ready = 1'b0; mdu_start = 1'b1;
        chk_flags("reset_flags", F_IDLE);
        check("reset_addr", jumpaddr, 32'h0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        chk_flags("idle", F_IDLE);

        // Load-use hazard on rs, then cleared.
        next_cycle();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        chk_flags("lu_rs", F_HAZ);
        next_cycle();
        chk_flags("lu_after", F_IDLE);
        next_cycle();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        chk_flags("lu_r0", F_IDLE);
        next_cycle();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        chk_flags("lu_rt", F_HAZ);
        next_cycle();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b0;
        chk_flags("lu_unused", F_IDLE);

        // imem not ready, no redirect.
        next_cycle();
        imem_ready = 1'b0;
        chk_flags("imem_wait", F_HAZ);

        // Simultaneous sources: exception wins.
        next_cycle();
        exc_req = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h00400040;
        id_jump = 1'b1; id_jump_target = 32'h00400200;
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        chk_flags("all_src_flags", F_REDIR);
        check("all_src_addr", jumpaddr, EXC);
        next_cycle();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h00400040;
        id_jump = 1'b1; id_jump_target = 32'h00400200;
        chk_flags("br_jmp_flags", F_REDIR);
        check("br_jmp_addr", jumpaddr, 32'h00400040);
        next_cycle();
        id_jump = 1'b1; id_jump_target = 32'h00400200;
        chk_flags("jump_flags", F_JUMP);
        check("jump_addr", jumpaddr, 32'h00400200);

        // MDU: four stall cycles after the issue cycle; branch ignored.
        next_cycle();
        mdu_start = 1'b1;
        chk_flags("mdu_issue", F_IDLE);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            if (i == 1) begin ex_branch_taken = 1'b1; ex_branch_target = 32'h00400040; end
            chk_flags($sformatf("mdu_c%0d", i), F_MDU);
        end
        next_cycle();
        chk_flags("mdu_done", F_IDLE);

        // MDU aborted by exception in cycle 2.
        next_cycle();
        mdu_start = 1'b1;
        next_cycle();
        chk_flags("mdu_ab_c1", F_MDU);
        next_cycle();
        exc_req = 1'b1;
        chk_flags("mdu_ab_flags", F_MDU_EXC);
        check("mdu_ab_addr", jumpaddr, EXC);
        next_cycle();
        chk_flags("mdu_ab_run", F_IDLE);

        // MDU aborted by exception while imem busy.
        next_cycle();
        mdu_start = 1'b1;
        next_cycle();
        exc_req = 1'b1; imem_ready = 1'b0;
        chk_flags("mdu_exw_flags", F_MDU_EXCW);
        next_cycle();
        chk_flags("mdu_exw_go", F_PEND_GO);
        check("mdu_exw_addr", jumpaddr, EXC);

        // Branch held for three imem-wait cycles.
        next_cycle();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h00400100; imem_ready = 1'b0;
        chk_flags("pend_c0", F_HOLD0);
        for (int i = 1; i <= 2; i++) begin
            next_cycle();
            imem_ready = 1'b0; id_jump = 1'b1; id_jump_target = 32'h00400200;
            chk_flags($sformatf("pend_c%0d", i), F_PEND);
        end
        next_cycle();
        chk_flags("pend_go", F_PEND_GO);
        check("pend_addr", jumpaddr, 32'h00400100);
        next_cycle();
        chk_flags("pend_run", F_IDLE);

        // Exception during the wait replaces the held target.
        next_cycle();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h00400100; imem_ready = 1'b0;
        next_cycle();
        exc_req = 1'b1; imem_ready = 1'b0;
        chk_flags("pend_exc_wait", F_PEND);
        next_cycle();
        check("pend_exc_addr", jumpaddr, EXC);

        // Exception in the same cycle imem becomes ready.
        next_cycle();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h00400100; imem_ready = 1'b0;
        next_cycle();
        exc_req = 1'b1;
        chk_flags("pend_exc_now", F_PEND_GO);
        check("pend_exc_now_addr", jumpaddr, EXC);

        // Reset in MDU_WAIT.
        next_cycle();
        mdu_start = 1'b1;
        next_cycle();
        rst = 1'b1;
        chk_flags("rst_mdu_flags", F_IDLE);
        next_cycle();
        chk_flags("rst_mdu_after", F_IDLE);

        // Reset in REDIR_PEND; stale target must not come back.
        next_cycle();
        ex_branch_taken = 1'b1; ex_branch_target = 32'h00400300; imem_ready = 1'b0;
        next_cycle();
        rst = 1'b1; imem_ready = 1'b0;
        chk_flags("rst_pend_flags", F_IDLE);
        next_cycle();
        chk_flags("rst_pend_after", F_IDLE);
        next_cycle();
        id_jump = 1'b1; id_jump_target = 32'h00400200; imem_ready = 1'b0;
        chk_flags("new_jump_hold", 7'b0101000);
        next_cycle();
        chk_flags("new_jump_go", F_PEND_GO);
        check("new_jump_addr", jumpaddr, 32'h00400200);

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
